// File: rtl/chirp_ref_pkg.sv
// Shared defaults and FSM encoding for the chirp reference coefficient sequencer.
package chirp_ref_pkg;
    localparam int ORDER  = 60;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int TAP_W  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/chirp_ref_sequencer_fifo.sv
// 2-entry skid FIFO holding {tap,last,re,im} beats; head reads as zero when empty.
module coef_skid_fifo #(
    parameter int W = 39
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            // Caller never pushes into a full FIFO nor pops an empty one.
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) ent0_q <= push_data_i;
                    else                 ent1_q <= push_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    ent0_q  <= ent1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_q <= push_data_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = (count_q != 2'd0) ? ent0_q : '0;
    assign count_o = count_q;
endmodule

// File: rtl/chirp_ref_sequencer.sv
// Sweeps the chirp coefficient ROMs 0..ORDER and streams {re,im,tap} beats with valid/ready.
module chirp_ref_sequencer
    import chirp_ref_pkg::*;
#(
    parameter int ORDER_P  = ORDER,
    parameter int ADDR_W_P = ADDR_W,
    parameter int DATA_W_P = DATA_W,
    parameter int TAP_W_P  = TAP_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                continuous_i,
    output logic                rom_en_o,
    output logic [ADDR_W_P-1:0] rom_addr_o,
    input  logic [DATA_W_P-1:0] rom_re_data_i,
    input  logic [DATA_W_P-1:0] rom_im_data_i,
    output logic [DATA_W_P-1:0] coef_re_o,
    output logic [DATA_W_P-1:0] coef_im_o,
    output logic [TAP_W_P-1:0]  coef_tap_o,
    output logic                coef_last_o,
    output logic                coef_valid_o,
    input  logic                coef_ready_i,
    output logic                busy_o,
    output logic                done_o
);
    localparam int BW = TAP_W_P + 1 + 2 * DATA_W_P;
    localparam logic [TAP_W_P-1:0] LAST_TAP = TAP_W_P'(ORDER_P);

    state_e               state_q;
    logic [TAP_W_P-1:0]   tap_q, pend_tap_q, addr_q;
    logic                 pending_q, done_q;
    logic [1:0]           fifo_cnt;
    logic [BW-1:0]        head, push_data;
    logic                 pop, push, issue;
    logic [2:0]           in_use;

    assign coef_valid_o = (fifo_cnt != 2'd0);
    assign pop          = coef_valid_o & coef_ready_i;
    assign push         = pending_q & ~abort_i;
    // Slots committed to buffered or in-flight beats once this cycle's accept retires.
    assign in_use       = 3'(fifo_cnt) + 3'(pending_q) - 3'(pop);
    assign issue        = (state_q == RUN) & ~abort_i & (in_use < 3'd2);
    assign push_data    = {pend_tap_q, pend_tap_q == LAST_TAP, rom_re_data_i, rom_im_data_i};

    coef_skid_fifo #(.W(BW)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (abort_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    assign {coef_tap_o, coef_last_o, coef_re_o, coef_im_o} = head;
    assign rom_en_o   = issue;
    assign rom_addr_o = ADDR_W_P'(issue ? tap_q : addr_q);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            pend_tap_q <= '0;
            addr_q     <= '0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            pending_q <= issue;
            if (issue) begin
                pend_tap_q <= tap_q;
                addr_q     <= tap_q;
                tap_q      <= (tap_q == LAST_TAP) ? '0 : tap_q + 1'b1;
            end
            if (abort_i) begin
                state_q <= IDLE;
                tap_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        state_q <= RUN;
                        tap_q   <= '0;
                    end
                    RUN: if (issue && tap_q == LAST_TAP && !continuous_i) state_q <= DRAIN;
                    DRAIN: begin
                        // Final beat retires this cycle (or already has): finish next edge.
                        if (!pending_q && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop))) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_chirp_ref_sequencer.sv
// Directed scenarios with randomized backpressure, checked against a sweep-level beat model.
module tb_chirp_ref_sequencer;
    localparam int ORDER = 60, ADDR_W = 32, DATA_W = 16, TAP_W = 6;

    logic              clk = 1'b0;
    logic              rst_n, start, abort, continuous, coef_ready;
    logic              rom_en, coef_last, coef_valid, busy, done;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_re, rom_im, coef_re, coef_im;
    logic [TAP_W-1:0]  coef_tap;

    always #5 clk = ~clk;

    chirp_ref_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .continuous_i(continuous), .rom_en_o(rom_en), .rom_addr_o(rom_addr),
        .rom_re_data_i(rom_re), .rom_im_data_i(rom_im), .coef_re_o(coef_re),
        .coef_im_o(coef_im), .coef_tap_o(coef_tap), .coef_last_o(coef_last),
        .coef_valid_o(coef_valid), .coef_ready_i(coef_ready), .busy_o(busy), .done_o(done)
    );

    int checks = 0, errors = 0;
    int cyc = 0, beats, dones, issues, outstanding, exp_tap, exp_issue;
    int last_acc_tap, last_acc_cyc, first_acc_cyc, done_cyc, start_cyc;
    logic stall_prev;
    logic [TAP_W+2*DATA_W-1:0] snap;

    function automatic logic [DATA_W-1:0] f_re(int t);
        return DATA_W'(t * 997 + 123);
    endfunction
    function automatic logic [DATA_W-1:0] f_im(int t);
        return DATA_W'((t * 313) ^ 32'h0000_A5A5);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        outstanding = 0; exp_tap = 0; exp_issue = 0; stall_prev = 1'b0;
    endtask

    task automatic clr();
        beats = 0; dones = 0; issues = 0; last_acc_tap = -1; first_acc_cyc = -1;
        last_acc_cyc = -1; done_cyc = -1;
    endtask

    // One clock: observe the cycle, advance the edge, then play the ROM's registered read.
    task automatic tick();
        logic acc, en, ab, rs;
        int a;
        #1;
        acc = coef_valid & coef_ready;
        en  = rom_en;
        a   = int'(rom_addr);
        ab  = abort;
        rs  = rst_n;
        if (stall_prev && coef_valid)
            chk("stable", 64'({coef_tap, coef_re, coef_im}), 64'(snap));
        if (en) begin
            chk("issue_room", 64'((outstanding - (acc ? 1 : 0)) < 2), 64'(1));
            chk("rom_addr", 64'(a), 64'(exp_issue));
            exp_issue = (exp_issue == ORDER) ? 0 : exp_issue + 1;
            outstanding++; issues++;
        end
        if (acc) begin
            chk("tap", 64'(coef_tap), 64'(exp_tap));
            chk("re", 64'(coef_re), 64'(f_re(exp_tap)));
            chk("im", 64'(coef_im), 64'(f_im(exp_tap)));
            chk("last", 64'(coef_last), 64'(exp_tap == ORDER));
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc; last_acc_tap = exp_tap;
            exp_tap = (exp_tap == ORDER) ? 0 : exp_tap + 1;
            outstanding--; beats++;
        end
        if (done) begin dones++; done_cyc = cyc; end
        stall_prev = coef_valid & ~coef_ready;
        snap = {coef_tap, coef_re, coef_im};
        @(posedge clk);
        #1;
        cyc++;
        rom_re = en ? f_re(a) : DATA_W'($urandom);
        rom_im = en ? f_im(a) : DATA_W'($urandom);
        if (ab || !rs) model_reset();
    endtask

    task automatic do_start();
        start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_tap(input int t, input int limit);
        int n = 0;
        while (last_acc_tap != t && n < limit) begin tick(); n++; end
        chk("wait_tap_timeout", 64'(last_acc_tap), 64'(t));
    endtask

    task automatic run_done(input int limit, input bit rnd);
        int n = 0;
        while (dones == 0 && n < limit) begin
            if (rnd) coef_ready = 1'($urandom_range(0, 1));
            tick(); n++;
        end
        chk("done_timeout", 64'(dones), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; continuous = 0; coef_ready = 1;
        rom_re = '0; rom_im = '0;
        model_reset(); clr();
        tick(); tick();
        chk("rst_valid", 64'(coef_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rom", 64'({rom_en, rom_addr}), 64'(0));
        rst_n = 1'b1;
        tick();

        // Reset mid-sweep, then full-rate sweep with latency and done timing.
        do_start();
        wait_tap(20, 100);
        rst_n = 1'b0;
        tick();
        #1;
        chk("mid_rst_outs", 64'({rom_en, rom_addr, coef_valid, coef_tap, coef_last, busy, done}), 64'(0));
        chk("mid_rst_data", 64'({coef_re, coef_im}), 64'(0));
        rst_n = 1'b1;
        tick();
        clr();
        do_start();
        #1;
        chk("lat_rom_en", 64'(rom_en), 64'(1));
        chk("lat_rom_addr", 64'(rom_addr), 64'(0));
        tick(); tick();
        #1;
        chk("lat_valid", 64'(coef_valid), 64'(1));
        chk("lat_tap", 64'(coef_tap), 64'(0));
        run_done(200, 1'b0);
        chk("full_beats", 64'(beats), 64'(ORDER + 1));
        chk("full_first", 64'(first_acc_cyc - start_cyc), 64'(3));
        chk("full_gapless", 64'(last_acc_cyc - first_acc_cyc), 64'(ORDER));
        chk("full_done_t", 64'(done_cyc - last_acc_cyc), 64'(1));
        #1;
        chk("full_busy", 64'(busy), 64'(0));
        tick(); tick();
        chk("full_dones", 64'(dones), 64'(1));

        // Random 50% backpressure.
        clr();
        do_start();
        run_done(2000, 1'b1);
        chk("rnd_beats", 64'(beats), 64'(ORDER + 1));
        chk("rnd_issues", 64'(issues), 64'(ORDER + 1));
        coef_ready = 1'b1;
        tick(); tick();
        chk("rnd_dones", 64'(dones), 64'(1));

        // Held off from cycle 0: exactly two reads outstanding.
        clr();
        coef_ready = 1'b0;
        do_start();
        repeat (10) tick();
        #1;
        chk("bp_issues", 64'(issues), 64'(2));
        chk("bp_rom_en", 64'(rom_en), 64'(0));
        chk("bp_head", 64'({coef_valid, coef_tap}), 64'({1'b1, 6'd0}));
        coef_ready = 1'b1;
        run_done(200, 1'b0);
        chk("bp_beats", 64'(beats), 64'(ORDER + 1));

        // Continuous wrap, then drop continuous part-way through the second sweep.
        clr();
        continuous = 1'b1;
        do_start();
        while (beats < ORDER + 1 + 31 && cyc < 20000) begin
            coef_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("cont_no_done", 64'(dones), 64'(0));
        chk("cont_wrap_tap", 64'(last_acc_tap), 64'(30));
        continuous = 1'b0;
        run_done(1000, 1'b1);
        chk("cont_beats", 64'(beats), 64'(2 * (ORDER + 1)));
        coef_ready = 1'b1;
        tick(); tick();
        chk("cont_dones", 64'(dones), 64'(1));

        // Abort with a full buffer, then start and abort together.
        clr();
        do_start();
        wait_tap(34, 100);
        coef_ready = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("ab_full_head", 64'({coef_valid, coef_tap}), 64'({1'b1, 6'd35}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk("ab_valid", 64'(coef_valid), 64'(0));
        chk("ab_busy", 64'({busy, rom_en}), 64'(0));
        coef_ready = 1'b1;
        repeat (4) tick();
        chk("ab_no_done", 64'(dones), 64'(0));
        clr();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (4) tick();
        chk("sa_busy", 64'(busy), 64'(0));
        chk("sa_issues", 64'(issues), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
